// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one quick_spi master between NUM_REQ clients. Round-robin grant,
//   one SPI transaction per grant, command latched at grant time, read data
//   returned with a one-cycle done pulse, per-transaction watchdog.
//
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   i_req              per-client request level, held until its done pulse
//   i_req_cmd          16-bit command per client, slice i = [16*i+15:16*i]
//   i_req_op           per-client operation (1 = write, 0 = read)
//   i_req_slave        2-bit slave select per client
//   o_done             one-cycle completion pulse to the granted client
//   o_err              with o_done: transaction aborted by watchdog
//   o_rdata            read data of last completed transaction
//   o_busy             arbiter not idle
//   o_spi_*            drive quick_spi (enable, start, outgoing, operation, slave)
//   i_spi_eot          quick_spi end_of_transaction pulse
//   i_spi_incoming     quick_spi incoming_data
module spi_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [16*NUM_REQ-1:0] i_req_cmd,
  input  logic [NUM_REQ-1:0]   i_req_op,
  input  logic [2*NUM_REQ-1:0] i_req_slave,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_err,
  output logic [7:0]           o_rdata,
  output logic                 o_busy,
  output logic                 o_spi_enable,
  output logic                 o_spi_start,
  output logic [15:0]          o_spi_outgoing,
  output logic                 o_spi_operation,
  output logic [1:0]           o_spi_slave,
  input  logic                 i_spi_eot,
  input  logic [7:0]           i_spi_incoming
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        op;
    logic [1:0]  slave;
  } cmd_t;

  state_t                 r_state;
  logic [IW-1:0]          r_rr_ptr;
  logic [IW-1:0]          r_gnt;
  logic [WW-1:0]          r_wd;
  logic [GW-1:0]          r_gc;
  cmd_t                   r_cmd;
  logic [NUM_REQ-1:0]     r_done;
  logic                   r_err;
  logic [7:0]             r_rdata;
  logic                   r_busy;
  logic                   r_spi_enable;
  logic                   r_spi_start;

  // Per-client views of the flat command / slave buses.
  logic [NUM_REQ-1:0][15:0] w_cmd;
  logic [NUM_REQ-1:0][1:0]  w_slave;
  assign w_cmd   = i_req_cmd;
  assign w_slave = i_req_slave;

  // Client index rr_ptr+k, wrapped to 0..NUM_REQ-1.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int unsigned s;
    s = (int'(p) + k) % NUM_REQ;
    return IW'(s);
  endfunction

  // Round-robin pick: scan rr_ptr+1 .. rr_ptr+NUM_REQ. Descending loop so
  // the smallest offset (the one just after the last winner) ends up winning.
  logic          w_hit;
  logic [IW-1:0] w_gnt;
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[wrap_idx(r_rr_ptr, k)]) begin
        w_hit = 1'b1;
        w_gnt = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= IW'(NUM_REQ - 1);
      r_gnt        <= '0;
      r_wd         <= '0;
      r_gc         <= '0;
      r_cmd        <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_busy       <= 1'b0;
      r_spi_enable <= 1'b0;
      r_spi_start  <= 1'b0;
    end else begin
      // done/err are single-cycle pulses
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt       <= w_gnt;
            r_rr_ptr    <= w_gnt;
            r_cmd.data  <= w_cmd[w_gnt];
            r_cmd.op    <= i_req_op[w_gnt];
            r_cmd.slave <= w_slave[w_gnt];
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_spi_enable <= 1'b1;
          r_spi_start  <= 1'b1;
          r_wd         <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          // eot takes priority over a watchdog expiry on the same cycle
          if (i_spi_eot) begin
            r_rdata       <= i_spi_incoming;
            r_done[r_gnt] <= 1'b1;
            r_spi_start   <= 1'b0;
            r_gc          <= '0;
            r_state       <= S_GAP;
          end else if (r_wd == WD_LAST) begin
            r_done[r_gnt] <= 1'b1;
            r_err         <= 1'b1;
            r_spi_start   <= 1'b0;
            r_spi_enable  <= 1'b0;
            r_gc          <= '0;
            r_state       <= S_GAP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_GAP: begin
          // ss_n stays high for GAP_CYC cycles before the next frame
          if (r_gc == GAP_LAST) begin
            r_spi_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_gc <= r_gc + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_rdata         = r_rdata;
  assign o_busy          = r_busy;
  assign o_spi_enable    = r_spi_enable;
  assign o_spi_start     = r_spi_start;
  assign o_spi_outgoing  = r_cmd.data;
  assign o_spi_operation = r_cmd.op;
  assign o_spi_slave     = r_cmd.slave;

endmodule
